// File: rtl/msrv32_pkg.sv
// msrv32 shared fetch definitions
// PC mux selects, fetch states, redirect kinds
package msrv32_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

  // Encoded so a larger value means higher priority
  typedef enum logic [1:0] {
    RD_NONE   = 2'b00,
    RD_BRANCH = 2'b01,
    RD_MRET   = 2'b10,
    RD_TRAP   = 2'b11
  } redirect_e;

  function automatic logic [1:0] pc_src_of(
    input redirect_e kind
  );
    logic [1:0] src;
    unique case (kind)
      RD_TRAP: src = PC_SRC_TRAP;
      RD_MRET: src = PC_SRC_EPC;
      default: src = PC_SRC_NEXT;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/msrv32_fetch_ctrl_arb.sv
// msrv32 redirect arbiter
// Priority resolution plus held redirect
module msrv32_redirect_arb
  import msrv32_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      trap_in,
  input  logic      mret_in,
  input  logic      branch_in,
  input  logic      advance_in,
  output redirect_e eff_out
);

  redirect_e live;
  redirect_e pend_kind_q;
  logic      pend_valid_q;

  // Highest-priority live request this cycle
  always_comb begin
    live = RD_NONE;
    priority case (1'b1)
      trap_in:   live = RD_TRAP;
      mret_in:   live = RD_MRET;
      branch_in: live = RD_BRANCH;
      default:   live = RD_NONE;
    endcase
  end

  // Held entry wins unless live is strictly higher
  always_comb begin
    eff_out = live;
    if (pend_valid_q && (pend_kind_q >= live))
      eff_out = pend_kind_q;
  end

  // Hold the winner until the fetch advances
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_valid_q <= 1'b0;
      pend_kind_q  <= RD_NONE;
    end else if (advance_in) begin
      pend_valid_q <= 1'b0;
      pend_kind_q  <= RD_NONE;
    end else if (eff_out != RD_NONE) begin
      pend_valid_q <= 1'b1;
      pend_kind_q  <= eff_out;
    end
  end

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// msrv32 fetch sequencer
// Owns the PC register and fetch FSM
module msrv32_fetch_ctrl
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ahb_ready_in,
  input  logic        stall_in,
  input  logic        trap_taken_in,
  input  logic        mret_in,
  input  logic        branch_taken_in,
  input  logic        misaligned_in,
  input  logic [31:0] pc_mux_in,
  output logic [1:0]  pc_src_out,
  output logic        branch_taken_out,
  output logic [31:0] pc_out,
  output logic        ireq_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        misaligned_instr_out
);

  fetch_state_e state_q;
  redirect_e    eff;
  logic         active;
  logic         advance;
  logic         is_branch;
  logic         commit;

  assign active  = (state_q != ST_BOOT);
  assign advance = active && ahb_ready_in
                   && !stall_in;

  msrv32_redirect_arb u_arb (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .trap_in    (trap_taken_in),
    .mret_in    (mret_in),
    .branch_in  (branch_taken_in),
    .advance_in (advance),
    .eff_out    (eff)
  );

  // Decode the winning redirect into mux controls
  always_comb begin
    is_branch  = (eff == RD_BRANCH);
    pc_src_out = PC_SRC_BOOT;
    if (active)
      pc_src_out = pc_src_of(eff);
    branch_taken_out = active && is_branch
                       && !misaligned_in;
    commit = advance
             && ((eff == RD_TRAP)
             || (eff == RD_MRET)
             || (is_branch && !misaligned_in));
    flush_out       = commit;
    instr_valid_out = advance && !commit;
    misaligned_instr_out = advance && is_branch
                           && misaligned_in;
  end

  // Fetch FSM, PC register and request flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_BOOT;
      pc_out   <= BOOT_ADDRESS;
      ireq_out <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_q  <= ST_RUN;
          ireq_out <= 1'b1;
        end
        ST_RUN, ST_HOLD: begin
          ireq_out <= 1'b1;
          if (advance) begin
            state_q <= ST_RUN;
            pc_out  <= pc_mux_in;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q  <= ST_BOOT;
          ireq_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Bench for msrv32_fetch_ctrl
// Directed steps then random traffic vs model
module tb_msrv32_fetch_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        ahb_ready_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        trap_taken_in = 1'b0;
  logic        mret_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic        misaligned_in = 1'b0;
  logic [31:0] pc_mux_in = 32'h0;
  logic [1:0]  pc_src_out;
  logic        branch_taken_out;
  logic [31:0] pc_out;
  logic        ireq_out;
  logic        instr_valid_out;
  logic        flush_out;
  logic        misaligned_instr_out;

  int tests = 0;
  int failed = 0;

  logic [31:0] m_pc;
  int          m_pend;
  bit          m_boot;

  always #5 clk_in = ~clk_in;

  msrv32_fetch_ctrl #(.BOOT_ADDRESS(BOOT)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .ahb_ready_in         (ahb_ready_in),
    .stall_in             (stall_in),
    .trap_taken_in        (trap_taken_in),
    .mret_in              (mret_in),
    .branch_taken_in      (branch_taken_in),
    .misaligned_in        (misaligned_in),
    .pc_mux_in            (pc_mux_in),
    .pc_src_out           (pc_src_out),
    .branch_taken_out     (branch_taken_out),
    .pc_out               (pc_out),
    .ireq_out             (ireq_out),
    .instr_valid_out      (instr_valid_out),
    .flush_out            (flush_out),
    .misaligned_instr_out (misaligned_instr_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    ahb_ready_in = 1'b0;
    stall_in = 1'b0;
    trap_taken_in = 1'b0;
    mret_in = 1'b0;
    branch_taken_in = 1'b0;
    misaligned_in = 1'b0;
    #1;
    m_pc = BOOT;
    m_pend = 0;
    m_boot = 1'b1;
    chk("rst_pc", pc_out, BOOT);
    chk("rst_src", {30'b0, pc_src_out}, 32'd0);
    chk("rst_ireq", {31'b0, ireq_out}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid_out}, 32'd0);
    chk("rst_flush", {31'b0, flush_out}, 32'd0);
    chk("rst_mis", {31'b0, misaligned_instr_out}, 32'd0);
    chk("rst_bt", {31'b0, branch_taken_out}, 32'd0);
    #1 rst_n_in = 1'b1;
  endtask

  // Model: priorities trap=3, mret=2, branch=1, none=0
  task automatic cyc(input logic rdy, input logic st,
                     input logic tr, input logic mr,
                     input logic br, input logic mis,
                     input logic [31:0] nxt);
    int  live;
    int  eff;
    int  src;
    bit  adv;
    bit  commit;
    ahb_ready_in = rdy;
    stall_in = st;
    trap_taken_in = tr;
    mret_in = mr;
    branch_taken_in = br;
    misaligned_in = mis;
    pc_mux_in = nxt;
    live = tr ? 3 : (mr ? 2 : (br ? 1 : 0));
    eff = (m_pend > live) ? m_pend : live;
    adv = !m_boot && rdy && !st;
    commit = adv && (eff >= 2 || (eff == 1 && !mis));
    if (m_boot) src = 0;
    else if (eff == 3) src = 2;
    else if (eff == 2) src = 1;
    else src = 3;
    #1;
    chk("pc_src", {30'b0, pc_src_out}, src);
    chk("ireq", {31'b0, ireq_out}, {31'b0, !m_boot});
    chk("branch_taken", {31'b0, branch_taken_out},
        {31'b0, !m_boot && eff == 1 && !mis});
    chk("flush", {31'b0, flush_out}, {31'b0, commit});
    chk("instr_valid", {31'b0, instr_valid_out},
        {31'b0, adv && !commit});
    chk("misaligned", {31'b0, misaligned_instr_out},
        {31'b0, adv && eff == 1 && mis});
    @(posedge clk_in);
    if (adv) m_pc = nxt;
    m_pend = adv ? 0 : eff;
    m_boot = 1'b0;
    #1;
    chk("pc", pc_out, m_pc);
  endtask

  initial begin
    bit rdy, st, tr, mr, br, mis;
    @(posedge clk_in);
    #1;
    do_reset();
    // boot cycle then sequential fetch
    cyc(1, 0, 0, 0, 0, 0, m_pc + 4);
    chk("boot_pc", pc_out, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, m_pc + 4);
    cyc(1, 0, 0, 0, 0, 0, m_pc + 4);
    chk("seq_pc", pc_out, 32'h8);
    // bus not ready for three cycles
    repeat (3) cyc(0, 0, 0, 0, 0, 0, m_pc + 4);
    chk("hold_pc", pc_out, 32'h8);
    cyc(1, 0, 0, 0, 0, 0, m_pc + 4);
    chk("resume_pc", pc_out, 32'hC);
    // branch held while bus not ready
    cyc(0, 0, 0, 0, 1, 0, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 32'h100);
    chk("branch_pc", pc_out, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 32'h104);
    // trap beats simultaneous branch
    cyc(1, 0, 1, 0, 1, 0, 32'h200);
    chk("trap_pc", pc_out, 32'h200);
    cyc(1, 0, 0, 0, 0, 0, 32'h204);
    chk("trap_after_pc", pc_out, 32'h204);
    // misaligned branch target
    cyc(1, 0, 0, 0, 0, 0, 32'h10);
    cyc(1, 0, 0, 0, 1, 1, 32'h14);
    chk("mis_pc", pc_out, 32'h14);
    // reset while holding a pending mret
    cyc(0, 0, 0, 1, 0, 0, 32'h300);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, m_pc + 4);
    cyc(1, 0, 0, 0, 0, 0, m_pc + 4);
    chk("post_rst_pc", pc_out, 32'h4);
    // wrap at top of address space
    cyc(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC + 32'd4);
    chk("wrap_pc", pc_out, 32'h0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 96) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 4) == 0);
      tr  = ($urandom_range(0, 11) == 0);
      mr  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 4) == 0);
      mis = ($urandom_range(0, 3) == 0);
      cyc(rdy, st, tr, mr, br, mis,
          {$urandom(), 2'b00} >> 2 << 2);
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
